// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//
// Sits on the processor's data-memory port. Accesses whose address_dmem[11:8]
// matches MMIO_PAGE are served by a small peripheral page. All other accesses
// are forwarded to the dmem syncram. Page read data is registered, so both
// sources return data one cycle after the address is presented.
//
// Page registers (address_dmem[7:0]):
//   0xF0 TXDATA  - write pushes data[7:0] into the output FIFO; reads 0
//   0xF1 STATUS  - [6:0] count, [7] empty, [8] full, [9] sticky OVF;
//                  a write with data[9]=1 clears OVF
//   0xF2 CYCLES  - free-running counter; a write loads it
//   0xF3 SCRATCH - 32-bit read/write
//
// Optional feature macro: MMIO_CYCLE_COUNTER_EN. When it is undefined, no
// counter is built, CYCLES reads 0 and writes to it are ignored.
//
// Ports:
//   clock, reset           - rising-edge clock; synchronous active-high reset
//   address_dmem/data/wren - processor dmem request
//   q_dmem                 - read data returned to the processor
//   mem_address/mem_data   - passthrough to the dmem syncram
//   mem_wren               - wren, gated off for page hits
//   mem_q                  - syncram read data (one cycle latency)
//   tx_valid/tx_byte       - FIFO head towards the external consumer
//   tx_ready               - consumer takes the head this cycle

module dmem_mmio_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  MMIO_PAGE  = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [11:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [7:0] OffTxData  = 8'hF0;
  localparam logic [7:0] OffStatus  = 8'hF1;
  localparam logic [7:0] OffCycles  = 8'hF2;
  localparam logic [7:0] OffScratch = 8'hF3;

  // Decode
  logic       hit;
  logic [7:0] offset;

  assign hit    = (address_dmem[11:8] == MMIO_PAGE);
  assign offset = address_dmem[7:0];

  assign mem_address = address_dmem;
  assign mem_data    = data;
  assign mem_wren    = wren & ~hit;

  logic wr_page;
  assign wr_page = hit & wren;

  // Output FIFO
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            empty, full;
  logic            push_req, push_acc, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign tx_valid = ~empty;
  assign tx_byte  = empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign pop      = tx_valid & tx_ready;
  assign push_req = wr_page & (offset == OffTxData);
  // A push into a full FIFO still lands when the head retires in the same cycle.
  assign push_acc = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (wr_page && (offset == OffStatus) && data[9]) ovf_d = 1'b0;
    if (push_req && !push_acc)                       ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && push_acc) fifo_mem[wr_ptr_q] <= data[7:0];
  end

  // Scratch register
  logic [31:0] scratch_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
    end else if (wr_page && (offset == OffScratch)) begin
      scratch_q <= data;
    end
  end

  // Cycle counter
  logic [31:0] cycles_rd;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;
  logic        wr_cycles;

  assign wr_cycles = wr_page & (offset == OffCycles);

  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_q <= '0;
    end else if (wr_cycles) begin
      cycles_q <= data;
    end else begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  // Page read mux and registered return path
  logic [31:0] status;
  logic [31:0] rdata_d, rdata_q;
  logic        sel_q;

  assign status = {22'd0, ovf_q, full, empty, 7'(count_q)};

  always_comb begin
    rdata_d = '0;
    if (hit) begin
      unique case (offset)
        OffStatus:  rdata_d = status;
        OffCycles:  rdata_d = cycles_rd;
        OffScratch: rdata_d = scratch_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q   <= 1'b1;
      rdata_q <= '0;
    end else begin
      sel_q   <= hit;
      rdata_q <= rdata_d;
    end
  end

  assign q_dmem = sel_q ? rdata_q : mem_q;

endmodule
